booth_mult_arbiter: RTL and testbench



---
 rtl/booth_arb_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/booth_mult_arbiter.sv | 140 ++++++++++++++
 tb/tb_booth_mult_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_arb_pkg.sv
// Shared types and constants for the Booth multiplier arbiter.
//   state_t : arbiter FSM states
//   OP_W    : operand width fed to the multiplier core
//   PROD_W  : product width returned by the core
//   id_w()  : width of a requester index for n requesters (at least 1 bit)
package booth_arb_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick. Searches req upward starting at ptr,
// wrapping past the top port, and returns the first set bit.
//   req       : request vector
//   ptr       : highest-priority index this cycle
//   grant     : one-hot winner (all zero when no request)
//   grant_idx : binary index of the winner
//   grant_vld : any request present
module rr_arbiter
  import booth_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               grant_vld
);

  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // ptr < NUM_REQ, so a single subtraction performs the wrap
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_vld && req[idx]) begin
        grant_vld  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/booth_mult_arbiter.sv
// Shares one 8-bit signed Booth multiplier core between NUM_REQ requesters.
// Round-robin grant, stable operands while the core runs, one-cycle
// registered response pulse to the owner, watchdog abort on a hung core.
//   clk, reset           : clock, synchronous active-high reset
//   req_valid/a/b        : per-port requests, operands packed 8 bits per port
//   req_ready            : one-hot accept pulse (combinational)
//   resp_valid/m/err     : one-hot result pulse, product, timeout flag
//   mult_start/a/b       : registered drive to the core
//   mult_done/m          : core handshake back
//   busy                 : FSM not in IDLE
module booth_mult_arbiter
  import booth_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [OP_W*NUM_REQ-1:0]   req_a,
  input  logic [OP_W*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [PROD_W-1:0]         resp_m,
  output logic                      resp_err,
  output logic                      mult_start,
  output logic [OP_W-1:0]           mult_a,
  output logic [OP_W-1:0]           mult_b,
  input  logic                      mult_done,
  input  logic [PROD_W-1:0]         mult_m,
  output logic                      busy
);

  localparam int IW = id_w(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT);

  state_t              state, state_n;
  logic [IW-1:0]       ptr, ptr_n, owner, owner_n;
  logic [TW-1:0]       timer, timer_n;
  logic                start_n;
  logic [OP_W-1:0]     a_n, b_n;
  logic [NUM_REQ-1:0]  rv_n;
  logic [PROD_W-1:0]   rm_n;
  logic                re_n;

  logic [NUM_REQ-1:0]  grant;
  logic [IW-1:0]       grant_idx;
  logic                grant_vld;
  logic [NUM_REQ-1:0]  owner_oh;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign owner_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      owner      <= '0;
      timer      <= '0;
      mult_start <= 1'b0;
      mult_a     <= '0;
      mult_b     <= '0;
      resp_valid <= '0;
      resp_m     <= '0;
      resp_err   <= 1'b0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      owner      <= owner_n;
      timer      <= timer_n;
      mult_start <= start_n;
      mult_a     <= a_n;
      mult_b     <= b_n;
      resp_valid <= rv_n;
      resp_m     <= rm_n;
      resp_err   <= re_n;
    end
  end

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    owner_n   = owner;
    timer_n   = timer;
    start_n   = mult_start;
    a_n       = mult_a;
    b_n       = mult_b;
    rv_n      = '0;     // response is a single-cycle pulse
    rm_n      = resp_m;
    re_n      = resp_err;
    req_ready = '0;
    unique case (state)
      IDLE: begin
        // A done still high from a previous job must drop before a new start
        if (grant_vld && !mult_done) begin
          req_ready = grant;
          a_n       = req_a[int'(grant_idx)*OP_W +: OP_W];
          b_n       = req_b[int'(grant_idx)*OP_W +: OP_W];
          owner_n   = grant_idx;
          ptr_n     = (grant_idx == IW'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
          start_n   = 1'b1;
          timer_n   = '0;
          state_n   = BUSY;
        end
      end
      BUSY: begin
        start_n = 1'b1;
        timer_n = timer + 1'b1;
        // done has priority so a result landing on the last cycle is kept
        if (mult_done) begin
          rm_n    = mult_m;
          re_n    = 1'b0;
          rv_n    = owner_oh;
          start_n = 1'b0;
          state_n = DRAIN;
        end else if (timer == TW'(TIMEOUT-1)) begin
          rm_n    = '0;
          re_n    = 1'b1;
          rv_n    = owner_oh;
          start_n = 1'b0;
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        start_n = 1'b0;
        if (!mult_done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_booth_mult_arbiter.sv
module tb_booth_mult_arbiter;

  localparam int N  = 4;
  localparam int TO = 32;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_a = '0, req_b = '0;
  logic [N-1:0]   req_ready, resp_valid;
  logic [15:0]    resp_m;
  logic           resp_err, mult_start, busy;
  logic [7:0]     mult_a, mult_b;
  logic           mult_done = 1'b0;
  logic [15:0]    mult_m = '0;

  int checks = 0, errors = 0, cyc = 0, mptr = 0;
  int hang = 0, dly = 9, cnt = 0;

  booth_mult_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_m(resp_m), .resp_err(resp_err),
    .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
    .mult_done(mult_done), .mult_m(mult_m), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural core: done rises 10 cycles after start is first seen and
  // stays high until start drops; hang=1 models a core that never finishes.
  always @(posedge clk) begin
    if (reset || !mult_start) begin
      cnt <= 0;
      mult_done <= 1'b0;
    end else begin
      cnt <= cnt + 1;
      if (hang == 0 && cnt == dly) begin
        mult_done <= 1'b1;
        mult_m <= 16'($signed(mult_a) * $signed(mult_b));
      end
    end
  end

  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++)
      if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [15:0] prod(input logic signed [7:0] a, input logic signed [7:0] b);
    logic signed [15:0] r;
    r = a * b;
    return r;
  endfunction

  task automatic set_port(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    mptr = 0;
    #1;
  endtask

  // Waits for an accept, checks which port won, then the operands on the core.
  task automatic wait_grant(input logic [N-1:0] exp, input string nm, output int acc);
    int n, w;
    logic [N-1:0] g;
    logic [7:0] ea, eb;
    n = 0; w = 0;
    while (req_ready == '0 && n < 200) begin @(negedge clk); #1; n++; end
    acc = cyc;
    g = req_ready;
    for (int i = 0; i < N; i++) if (exp[i]) w = i;
    ea = req_a[w*8 +: 8];
    eb = req_b[w*8 +: 8];
    checks++;
    if (req_ready !== exp) begin
      errors++; $display("FAIL %s grant: got %b want %b", nm, req_ready, exp);
    end
    @(negedge clk); #1;
    req_valid = req_valid & ~g;
    checks++;
    if (mult_start !== 1'b1 || mult_a !== ea || mult_b !== eb) begin
      errors++;
      $display("FAIL %s core drive: start=%b a=%h b=%h want 1 %h %h", nm, mult_start, mult_a, mult_b, ea, eb);
    end
  endtask

  task automatic wait_resp(input int acc, input logic [N-1:0] ep, input logic [15:0] em,
                           input logic ee, input int rl, input int il, input string nm);
    int n;
    n = 0;
    while (resp_valid == '0 && n < 100) begin @(negedge clk); #1; n++; end
    checks++;
    if (resp_valid !== ep || cyc - acc != rl) begin
      errors++; $display("FAIL %s resp timing: valid=%b at +%0d want %b at +%0d", nm, resp_valid, cyc - acc, ep, rl);
    end
    checks++;
    if (resp_m !== em || resp_err !== ee || mult_start !== 1'b0) begin
      errors++; $display("FAIL %s resp data: m=%h err=%b start=%b want %h %b 0", nm, resp_m, resp_err, mult_start, em, ee);
    end
    @(negedge clk); #1;
    checks++;
    if (resp_valid !== '0) begin
      errors++; $display("FAIL %s resp pulse width: valid=%b want 0", nm, resp_valid);
    end
    n = 0;
    while (busy !== 1'b0 && n < 100) begin @(negedge clk); #1; n++; end
    checks++;
    if (cyc - acc != il) begin
      errors++; $display("FAIL %s idle return: at +%0d want +%0d", nm, cyc - acc, il);
    end
  endtask

  // Serves every pending request in model round-robin order.
  task automatic serve_all(input string nm);
    logic [N-1:0] pend, e;
    int w, acc, prev;
    bit first;
    pend = req_valid; first = 1; prev = 0;
    while (pend != '0) begin
      w = pick(pend, mptr);
      e = '0; e[w] = 1'b1;
      wait_grant(e, nm, acc);
      if (!first) begin
        checks++;
        if (acc - prev != 14) begin
          errors++; $display("FAIL %s period: %0d want 14", nm, acc - prev);
        end
      end
      first = 0; prev = acc;
      mptr = (w + 1) % N;
      pend[w] = 1'b0;
      wait_resp(acc, e, prod(req_a[w*8 +: 8], req_b[w*8 +: 8]), 1'b0, 12, 14, nm);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || mult_start !== 1'b0 || mult_a !== 8'h0 || mult_b !== 8'h0 ||
        resp_valid !== '0 || resp_m !== 16'h0 || resp_err !== 1'b0) begin
      errors++; $display("FAIL reset state: busy=%b start=%b a=%h b=%h rv=%b m=%h err=%b want all 0",
                         busy, mult_start, mult_a, mult_b, resp_valid, resp_m, resp_err);
    end
    reset = 1'b0; mptr = 0;
    @(negedge clk); #1;
    checks++;
    if (req_ready !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL idle no request: ready=%b busy=%b want 0 0", req_ready, busy);
    end
  endtask

  task automatic test_single();
    set_port(0, 8'd3, 8'd5);
    req_valid = 4'b0001; #1;
    checks++;
    if (prod(8'd3, 8'd5) !== 16'h000F) begin
      errors++; $display("FAIL model 3*5: %h want 000f", prod(8'd3, 8'd5));
    end
    serve_all("single");
  endtask

  task automatic test_negative();
    set_port(1, 8'hF9, 8'h06);
    req_valid = 4'b0010; #1;
    serve_all("negative");
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < N; i++) set_port(i, 8'(i + 1), 8'd2);
    req_valid = 4'b1111; #1;
    serve_all("all_four");
    req_valid = 4'b0101; #1;
    serve_all("rerequest");
  endtask

  task automatic test_wrap();
    set_port(3, 8'h80, 8'h80);
    req_valid = 4'b1000; #1;
    serve_all("wrap_p3");
    set_port(1, 8'h7F, 8'h80);
    req_valid = 4'b1010; #1;
    serve_all("wrap");
  endtask

  task automatic test_timeout();
    logic [N-1:0] e;
    int acc, w;
    hang = 1;
    set_port(2, 8'd5, 8'd5);
    req_valid = 4'b0100; #1;
    w = pick(req_valid, mptr);
    e = '0; e[w] = 1'b1;
    wait_grant(e, "timeout", acc);
    mptr = (w + 1) % N;
    wait_resp(acc, e, 16'h0000, 1'b1, TO + 1, TO + 2, "timeout");
    hang = 0;
    // done first high exactly on the last allowed cycle: normal result wins
    dly = TO - 2;
    set_port(1, 8'hFD, 8'd4);
    req_valid = 4'b0010; #1;
    w = pick(req_valid, mptr);
    e = '0; e[w] = 1'b1;
    wait_grant(e, "tie", acc);
    mptr = (w + 1) % N;
    wait_resp(acc, e, 16'hFFF4, 1'b0, TO + 1, TO + 3, "tie");
    dly = 9;
  endtask

  task automatic test_random();
    logic [N-1:0] m;
    for (int r = 0; r < 8; r++) begin
      m = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) set_port(i, 8'($urandom), 8'($urandom));
      req_valid = m; #1;
      serve_all("random");
    end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] e;
    int acc, w;
    set_port(2, 8'd9, 8'd9);
    req_valid = 4'b0100; #1;
    w = pick(req_valid, mptr);
    e = '0; e[w] = 1'b1;
    wait_grant(e, "reset_mid", acc);
    mptr = (w + 1) % N;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (mult_start !== 1'b0 || resp_valid !== '0 || busy !== 1'b0 || resp_m !== 16'h0) begin
      errors++; $display("FAIL reset mid busy: start=%b rv=%b busy=%b m=%h want 0", mult_start, resp_valid, busy, resp_m);
    end
    reset = 1'b0; mptr = 0;
    set_port(0, 8'd11, 8'hF0);
    set_port(3, 8'd7, 8'd7);
    req_valid = 4'b1001; #1;
    serve_all("after_reset");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_negative();
    test_back_to_back();
    test_wrap();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
